// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM state codes,
// next-PC source codes, the default memory timeout and the latched class flags.
package mips_ctrl_pkg;

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_MEMORY    = 3'd3;
   localparam logic [2:0] ST_WRITEBACK = 3'd4;
   localparam logic [2:0] ST_HALT      = 3'd5;

   localparam logic [1:0] PCSEL_SEQ    = 2'd0;
   localparam logic [1:0] PCSEL_BRANCH = 2'd1;
   localparam logic [1:0] PCSEL_JUMP   = 2'd2;
   localparam logic [1:0] PCSEL_REG    = 2'd3;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

   typedef struct packed {
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic jump_reg;
      logic link;
      logic wr_reg;
      logic wr_hi;
      logic wr_lo;
      logic taken;
   } ctrl_flags_t;

   // Register jumps outrank absolute jumps, which outrank a taken branch.
   function automatic logic [1:0] select_next_pc(input ctrl_flags_t f);
      if (f.jump_reg)
         return PCSEL_REG;
      else if (f.jump)
         return PCSEL_JUMP;
      else if (f.branch && f.taken)
         return PCSEL_BRANCH;
      else
         return PCSEL_SEQ;
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts stalled data-memory cycles; expired flags the cycle that uses up the
// last allowed wait so the controller can halt on that same edge.
module mem_timeout_counter
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (clear)
         r_count <= '0;
      else if (enable)
         r_count <= r_count + 8'd1;
   end

   assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/cycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath strobes and counts retired instructions.
module cycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        load,
   input  logic        store,
   input  logic        branch,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic        link,
   input  logic        write_to_register,
   input  logic        write_to_hi,
   input  logic        write_to_lo,
   input  logic        halt_inst,
   input  logic        branch_taken,
   output logic        ir_en,
   output logic        pc_en,
   output logic [1:0]  pc_sel,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        reg_we,
   output logic        hi_we,
   output logic        lo_we,
   output logic [2:0]  state,
   output logic        halted,
   output logic        error,
   output logic [31:0] retired
);

   logic [2:0]  r_state;
   logic [2:0]  w_next_state;
   ctrl_flags_t r_flags;
   ctrl_flags_t w_live_flags;
   ctrl_flags_t w_flags;
   logic        r_error;
   logic [31:0] r_retired;
   logic        w_complete;
   logic        w_set_error;
   logic        w_mem_clear;
   logic        w_mem_stall;
   logic        w_mem_expired;

   always_comb begin
      w_live_flags.load     = load;
      w_live_flags.store    = store;
      w_live_flags.branch   = branch;
      w_live_flags.jump     = jump;
      w_live_flags.jump_reg = jump_reg;
      w_live_flags.link     = link;
      w_live_flags.wr_reg   = write_to_register;
      w_live_flags.wr_hi    = write_to_hi;
      w_live_flags.wr_lo    = write_to_lo;
      w_live_flags.taken    = branch_taken;
   end

   // EXECUTE acts on the decoder's live flags; later states use the copy latched there.
   assign w_flags     = (r_state == ST_EXECUTE) ? w_live_flags : r_flags;
   assign w_mem_clear = (r_state != ST_MEMORY);
   assign w_mem_stall = (r_state == ST_MEMORY) && !dmem_ready;

   mem_timeout_counter #(
      .TIMEOUT(MEM_TIMEOUT)
   ) u_mem_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_mem_clear),
      .enable  (w_mem_stall),
      .expired (w_mem_expired)
   );

   // Strobes are gated by rst_n so they vanish the moment reset asserts.
   always_comb begin
      w_next_state = r_state;
      w_complete   = 1'b0;
      w_set_error  = 1'b0;
      ir_en        = 1'b0;
      pc_en        = 1'b0;
      pc_sel       = PCSEL_SEQ;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_we       = 1'b0;
      hi_we        = 1'b0;
      lo_we        = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_FETCH: begin
               if (imem_ready) begin
                  ir_en        = 1'b1;
                  w_next_state = ST_DECODE;
               end
            end
            ST_DECODE: begin
               w_next_state = halt_inst ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (w_flags.load || w_flags.store)
                  w_next_state = ST_MEMORY;
               else if (w_flags.wr_reg || w_flags.wr_hi || w_flags.wr_lo || w_flags.link)
                  w_next_state = ST_WRITEBACK;
               else
                  w_complete = 1'b1;
            end
            ST_MEMORY: begin
               dmem_req = 1'b1;
               dmem_we  = w_flags.store && !w_flags.load;
               if (dmem_ready) begin
                  if (w_flags.load)
                     w_next_state = ST_WRITEBACK;
                  else
                     w_complete = 1'b1;
               end else if (w_mem_expired) begin
                  w_next_state = ST_HALT;
                  w_set_error  = 1'b1;
               end
            end
            ST_WRITEBACK: begin
               reg_we     = w_flags.wr_reg || w_flags.link;
               hi_we      = w_flags.wr_hi;
               lo_we      = w_flags.wr_lo;
               w_complete = 1'b1;
            end
            ST_HALT: begin
               w_next_state = ST_HALT;
            end
            default: begin
               w_next_state = ST_HALT;
               w_set_error  = 1'b1;
            end
         endcase
         if (w_complete) begin
            pc_en        = 1'b1;
            pc_sel       = select_next_pc(w_flags);
            w_next_state = ST_FETCH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_FETCH;
         r_flags   <= '0;
         r_error   <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_EXECUTE)
            r_flags <= w_live_flags;
         if (w_set_error)
            r_error <= 1'b1;
         if (w_complete)
            r_retired <= r_retired + 32'd1;
      end
   end

   assign state   = r_state;
   assign halted  = (r_state == ST_HALT);
   assign error   = r_error;
   assign retired = r_retired;

endmodule

// File: tb/tb_cycle_controller.sv
// Self-checking bench for cycle_controller: directed instruction table, reset and
// timeout sequences, then random instructions against a latency/strobe model.
module tb_cycle_controller;

   localparam int MemTimeout = 15;

   localparam logic [10:0] F_LOAD   = 11'h001;
   localparam logic [10:0] F_STORE  = 11'h002;
   localparam logic [10:0] F_BRANCH = 11'h004;
   localparam logic [10:0] F_JUMP   = 11'h008;
   localparam logic [10:0] F_JR     = 11'h010;
   localparam logic [10:0] F_LINK   = 11'h020;
   localparam logic [10:0] F_WRREG  = 11'h040;
   localparam logic [10:0] F_WRHI   = 11'h080;
   localparam logic [10:0] F_WRLO   = 11'h100;
   localparam logic [10:0] F_TAKEN  = 11'h200;
   localparam logic [10:0] F_HALT   = 11'h400;

   typedef struct {
      int lat;
      int pcSel;
      int irEn;
      int req;
      int we;
      int regWe;
      int hiWe;
      int loWe;
      int halted;
      int err;
   } obs_t;

   typedef struct {
      string       name;
      logic [10:0] f;
      int          fw;
      int          mw;
      int          lat;
      int          pcSel;
      int          regWe;
      int          req;
      int          we;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ready, dmem_ready;
   logic        load, store, branch, jump, jump_reg, link;
   logic        write_to_register, write_to_hi, write_to_lo, halt_inst, branch_taken;
   logic        ir_en, pc_en, dmem_req, dmem_we, reg_we, hi_we, lo_we, halted, error;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [31:0] retired;

   int checks = 0;
   int passed = 0;
   int expRetired = 0;

   cycle_controller #(.MEM_TIMEOUT(MemTimeout)) dut (
      .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .load(load), .store(store), .branch(branch), .jump(jump), .jump_reg(jump_reg),
      .link(link), .write_to_register(write_to_register), .write_to_hi(write_to_hi),
      .write_to_lo(write_to_lo), .halt_inst(halt_inst), .branch_taken(branch_taken),
      .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .reg_we(reg_we), .hi_we(hi_we), .lo_we(lo_we),
      .state(state), .halted(halted), .error(error), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic bit has(input logic [10:0] f, input logic [10:0] m);
      return (f & m) != '0;
   endfunction

   // Instruction-level expectations straight from the latency and strobe rules.
   function automatic obs_t modelInstr(input logic [10:0] f, input int fw, input int mw);
      obs_t e;
      bit isMem, isLoad, isStore, doWb;
      e = '{default: 0};
      e.irEn  = 1;
      isMem   = has(f, F_LOAD) || has(f, F_STORE);
      isLoad  = has(f, F_LOAD);
      isStore = has(f, F_STORE) && !isLoad;
      if (has(f, F_HALT)) begin
         e.lat    = fw + 3;
         e.halted = 1;
         return e;
      end
      if (isMem && mw >= MemTimeout) begin
         e.lat    = fw + 3 + MemTimeout + 1;
         e.req    = MemTimeout;
         e.we     = isStore ? MemTimeout : 0;
         e.halted = 1;
         e.err    = 1;
         return e;
      end
      doWb = isLoad || (!isMem && (has(f, F_WRREG) || has(f, F_WRHI) ||
                                   has(f, F_WRLO) || has(f, F_LINK)));
      e.lat   = fw + 3 + (isMem ? mw + 1 : 0) + (doWb ? 1 : 0);
      e.req   = isMem ? mw + 1 : 0;
      e.we    = isStore ? mw + 1 : 0;
      e.regWe = (doWb && (has(f, F_WRREG) || has(f, F_LINK))) ? 1 : 0;
      e.hiWe  = (doWb && has(f, F_WRHI)) ? 1 : 0;
      e.loWe  = (doWb && has(f, F_WRLO)) ? 1 : 0;
      if (has(f, F_JR))
         e.pcSel = 3;
      else if (has(f, F_JUMP))
         e.pcSel = 2;
      else if (has(f, F_BRANCH) && has(f, F_TAKEN))
         e.pcSel = 1;
      return e;
   endfunction

   function automatic logic [10:0] randFlags();
      logic [10:0] f = '0;
      for (int b = 0; b < 10; b++)
         if ($urandom_range(0, 3) == 0) f[b] = 1'b1;
      return f;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected)
         passed++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic driveFlags(input logic [10:0] f);
      load              = f[0];
      store             = f[1];
      branch            = f[2];
      jump              = f[3];
      jump_reg          = f[4];
      link              = f[5];
      write_to_register = f[6];
      write_to_hi       = f[7];
      write_to_lo       = f[8];
      branch_taken      = f[9];
      halt_inst         = f[10];
   endtask

   task automatic resetDut();
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      driveFlags('0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expRetired = 0;
   endtask

   // Runs one instruction from FETCH; starts and ends just after a rising edge.
   task automatic applyStimulus(input logic [10:0] f, input int fw, input int mw, output obs_t o);
      bit done = 0;
      o = '{default: 0};
      driveFlags(f);
      for (int k = 0; k < 60 && !done; k++) begin
         imem_ready = (k >= fw) && (o.irEn == 0);
         dmem_ready = (o.req >= mw);
         @(negedge clk);
         o.irEn  += int'(ir_en);
         o.req   += int'(dmem_req);
         o.we    += int'(dmem_we);
         o.regWe += int'(reg_we);
         o.hiWe  += int'(hi_we);
         o.loWe  += int'(lo_we);
         if (pc_en || halted) begin
            done     = 1;
            o.lat    = k + 1;
            o.pcSel  = int'(pc_sel);
            o.halted = int'(halted);
            o.err    = int'(error);
         end
         @(posedge clk);
         #1;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   task automatic compareObs(input string tag, input obs_t o, input obs_t e);
      checkOutput({tag, ".latency"}, o.lat, e.lat);
      checkOutput({tag, ".pc_sel"}, o.pcSel, e.pcSel);
      checkOutput({tag, ".ir_en"}, o.irEn, e.irEn);
      checkOutput({tag, ".dmem_req"}, o.req, e.req);
      checkOutput({tag, ".dmem_we"}, o.we, e.we);
      checkOutput({tag, ".reg_we"}, o.regWe, e.regWe);
      checkOutput({tag, ".hi_we"}, o.hiWe, e.hiWe);
      checkOutput({tag, ".lo_we"}, o.loWe, e.loWe);
      checkOutput({tag, ".halted"}, o.halted, e.halted);
      checkOutput({tag, ".error"}, o.err, e.err);
   endtask

   initial begin
      vec_t vecs[11];
      obs_t o, e;
      bit   found;

      vecs[0]  = '{"add",       F_WRREG,                   0, 0, 4, 0, 1, 0, 0};
      vecs[1]  = '{"beqTaken",  F_BRANCH | F_TAKEN,        0, 0, 3, 1, 0, 0, 0};
      vecs[2]  = '{"beqNot",    F_BRANCH,                  0, 0, 3, 0, 0, 0, 0};
      vecs[3]  = '{"lwWait3",   F_LOAD | F_WRREG,          0, 3, 8, 0, 1, 4, 0};
      vecs[4]  = '{"sw",        F_STORE,                   0, 0, 4, 0, 0, 1, 1};
      vecs[5]  = '{"jal",       F_JUMP | F_LINK,           0, 0, 4, 2, 1, 0, 0};
      vecs[6]  = '{"jr",        F_JR,                      0, 0, 3, 3, 0, 0, 0};
      vecs[7]  = '{"mthi",      F_WRHI,                    0, 0, 4, 0, 0, 0, 0};
      vecs[8]  = '{"ldPlusSt",  F_LOAD | F_STORE | F_WRREG, 0, 1, 6, 0, 1, 2, 0};
      vecs[9]  = '{"addFetch2", F_WRREG,                   2, 0, 6, 0, 1, 0, 0};
      vecs[10] = '{"swWait14",  F_STORE,                   1, 14, 19, 0, 0, 15, 15};

      // Outputs while reset is held, with inputs that would otherwise fire ir_en.
      rst_n      = 1'b0;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      driveFlags(F_LOAD | F_STORE);
      #7;
      checkOutput("reset.state", state, 0);
      checkOutput("reset.ir_en", ir_en, 0);
      checkOutput("reset.pc_en", pc_en, 0);
      checkOutput("reset.pc_sel", pc_sel, 0);
      checkOutput("reset.dmem_req", dmem_req, 0);
      checkOutput("reset.halted", halted, 0);
      checkOutput("reset.error", error, 0);
      checkOutput("reset.retired", retired, 0);

      // The first rising edge after release already evaluates FETCH.
      driveFlags('0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("firstEdge.state", state, 1);
      imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("firstEdge.pc_en", pc_en, 1);
      @(posedge clk);
      #1;
      checkOutput("firstEdge.retired", retired, 1);
      expRetired = 1;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].f, vecs[i].fw, vecs[i].mw, o);
         expRetired++;
         checkOutput({vecs[i].name, ".latency"}, o.lat, vecs[i].lat);
         checkOutput({vecs[i].name, ".pc_sel"}, o.pcSel, vecs[i].pcSel);
         checkOutput({vecs[i].name, ".ir_en"}, o.irEn, 1);
         checkOutput({vecs[i].name, ".reg_we"}, o.regWe, vecs[i].regWe);
         checkOutput({vecs[i].name, ".dmem_req"}, o.req, vecs[i].req);
         checkOutput({vecs[i].name, ".dmem_we"}, o.we, vecs[i].we);
         checkOutput({vecs[i].name, ".retired"}, retired, expRetired);
      end

      // Reset arriving mid-MEMORY of a store must drop the request at once.
      driveFlags(F_STORE);
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      found      = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (state == 3'd3) found = 1;
      end
      checkOutput("midMem.reached", found, 1);
      checkOutput("midMem.weBefore", dmem_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midMem.dmem_req", dmem_req, 0);
      checkOutput("midMem.dmem_we", dmem_we, 0);
      checkOutput("midMem.state", state, 0);
      checkOutput("midMem.retired", retired, 0);
      @(negedge clk);
      rst_n      = 1'b1;
      imem_ready = 1'b0;
      driveFlags('0);
      @(posedge clk);
      #1;
      expRetired = 0;

      // Store whose memory never answers: fifteen stalled cycles, then halt with error.
      applyStimulus(F_STORE, 0, 1000, o);
      checkOutput("timeout.latency", o.lat, 19);
      checkOutput("timeout.dmem_req", o.req, 15);
      checkOutput("timeout.dmem_we", o.we, 15);
      checkOutput("timeout.halted", o.halted, 1);
      checkOutput("timeout.error", o.err, 1);
      imem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("timeout.holdState", state, 5);
         checkOutput("timeout.holdWe", dmem_we, 0);
         checkOutput("timeout.holdIrEn", ir_en, 0);
         checkOutput("timeout.holdRetired", retired, expRetired);
      end
      resetDut();
      checkOutput("timeout.errorCleared", error, 0);

      applyStimulus(F_HALT | F_WRREG, 1, 0, o);
      compareObs("haltInst", o, modelInstr(F_HALT | F_WRREG, 1, 0));
      checkOutput("haltInst.retired", retired, expRetired);
      resetDut();

      for (int i = 0; i < 40; i++) begin
         logic [10:0] f;
         int fw, mw;
         f  = randFlags();
         fw = $urandom_range(0, 3);
         mw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 4);
         e  = modelInstr(f, fw, mw);
         applyStimulus(f, fw, mw, o);
         if (!e.halted) expRetired++;
         compareObs($sformatf("rand%0d", i), o, e);
         checkOutput($sformatf("rand%0d.retired", i), retired, expRetired);
         if (e.halted || o.halted != 0) resetDut();
      end

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
